// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and frame constants,
// also used by the receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int CLKS_PER_BIT_DEFAULT = 87;
    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS           = 10;

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO that buffers bytes waiting for the
// transmitter. rd_data always shows the head entry while empty is low.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_10,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       full,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk_10) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_10) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: byte FIFO in front of a start/data/stop serialiser.
// state | meaning
// IDLE  | line high, waiting for the FIFO to hold a byte
// START | start bit (line low) for one bit period
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | stop bit (line high); chains straight into START if more bytes wait
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_10,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       uart,
    output logic       busy
);

    localparam int             BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int             BIT_W     = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_cnt_nxt;
    logic [BIT_W-1:0]  bit_idx;
    logic [BIT_W-1:0]  bit_idx_nxt;
    logic [7:0]        shift;
    logic [7:0]        shift_nxt;
    logic              uart_q;
    logic              uart_nxt;
    logic              busy_q;
    logic              baud_done;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_rd;
    logic [7:0]        fifo_data;

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_10 (clk_10),
        .reset  (reset),
        .wr_data(data),
        .wr_en  (valid),
        .full   (fifo_full),
        .rd_en  (fifo_rd),
        .rd_data(fifo_data),
        .empty  (fifo_empty)
    );

    assign ready     = !fifo_full;
    assign uart      = uart_q;
    assign busy      = busy_q;
    assign baud_done = (baud_cnt == BAUD_LAST);

    // uart_nxt is the level the line takes after the next edge, so the pin
    // lags the state by one cycle and comes straight from a flop.
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_done ? '0 : baud_cnt + 1'b1;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift;
        fifo_rd      = 1'b0;
        uart_nxt     = 1'b1;
        case (state)
            IDLE: begin
                baud_cnt_nxt = '0;
                if (!fifo_empty) begin
                    fifo_rd   = 1'b1;
                    shift_nxt = fifo_data;
                    state_nxt = START;
                end
            end
            START: begin
                uart_nxt = 1'b0;
                if (baud_done) begin
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                uart_nxt = shift[0];
                if (baud_done) begin
                    shift_nxt = shift >> 1;
                    if (bit_idx == BIT_LAST) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                uart_nxt = 1'b1;
                if (baud_done) begin
                    if (!fifo_empty) begin
                        fifo_rd   = 1'b1;
                        shift_nxt = fifo_data;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_10) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shift    <= shift_nxt;
            uart_q   <= uart_nxt;
            busy_q   <= (state != IDLE) || !fifo_empty;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a default-rate instance and a 2-clock-per-bit instance,
// each watched by a line decoder that checks every frame against the bytes accepted.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB_A = CLKS_PER_BIT_DEFAULT;
    localparam int CPB_B = 2;

    logic       clk_10 = 1'b0;
    logic [1:0] reset_w = 2'b11;
    logic [1:0] valid_w = 2'b00;
    logic [1:0] ready_w;
    logic [1:0] uart_w;
    logic [1:0] busy_w;
    logic [7:0] data_w [2];

    int cyc = 0;
    int n_checks = 0;
    int n_bad = 0;
    int gen [2]        = '{default: 0};
    int nstart [2]     = '{default: 0};
    int last_start [2] = '{default: 0};
    int prev_start [2] = '{default: 0};
    int nframes [2]    = '{default: 0};
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    always #5 clk_10 = ~clk_10;
    always @(posedge clk_10) cyc <= cyc + 1;

    uart_tx #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(4)) dut_a (
        .clk_10(clk_10), .reset(reset_w[0]), .data(data_w[0]), .valid(valid_w[0]),
        .ready(ready_w[0]), .uart(uart_w[0]), .busy(busy_w[0])
    );

    uart_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(4)) dut_b (
        .clk_10(clk_10), .reset(reset_w[1]), .data(data_w[1]), .valid(valid_w[1]),
        .ready(ready_w[1]), .uart(uart_w[1]), .busy(busy_w[1])
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Ideal 8N1 line level for frame bit k (0 = start, 9 = stop).
    function automatic logic ideal_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == FRAME_BITS - 1) return 1'b1;
        return b[k-1];
    endfunction

    function automatic int q_size(input int w);
        return (w == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic monitor(input int w, input int cpb);
        logic prev = 1'b1;
        forever begin
            @(negedge clk_10);
            if (prev === 1'b1 && uart_w[w] === 1'b0) begin
                logic       samp [];
                int         g;
                bit         aborted;
                logic [7:0] got;
                logic [7:0] want;
                int         errs;
                samp = new[FRAME_BITS * cpb];
                g = gen[w];
                aborted = 1'b0;
                prev_start[w] = last_start[w];
                last_start[w] = cyc;
                nstart[w]++;
                samp[0] = uart_w[w];
                for (int i = 1; i < FRAME_BITS * cpb; i++) begin
                    @(negedge clk_10);
                    if (gen[w] != g) begin
                        aborted = 1'b1;
                        break;
                    end
                    samp[i] = uart_w[w];
                end
                if (!aborted) begin
                    got = '0;
                    for (int k = 0; k < DATA_BITS; k++) got[k] = samp[(k + 1) * cpb + cpb / 2];
                    check_val(w == 0 ? "frame_expected_a" : "frame_expected_b", int'(q_size(w) != 0), 1);
                    if (q_size(w) != 0) begin
                        want = (w == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check_val(w == 0 ? "frame_byte_a" : "frame_byte_b", got, want);
                        errs = 0;
                        for (int i = 0; i < FRAME_BITS * cpb; i++)
                            if (samp[i] !== ideal_bit(want, i / cpb)) errs++;
                        check_val(w == 0 ? "frame_wave_a" : "frame_wave_b", errs, 0);
                    end
                    nframes[w]++;
                end
            end
            prev = uart_w[w];
        end
    endtask

    initial monitor(0, CPB_A);
    initial monitor(1, CPB_B);

    // Offer a byte starting now (just after a falling edge); returns just after the accepting edge.
    task automatic send_byte(input int w, input logic [7:0] b, output int acc_cyc, output bit stalled);
        int t = 0;
        stalled = 1'b0;
        acc_cyc = -1;
        data_w[w]  = b;
        valid_w[w] = 1'b1;
        while (!ready_w[w] && t < 20000) begin
            stalled = 1'b1;
            @(negedge clk_10);
            t++;
        end
        if (!ready_w[w]) begin
            check_val("ready_timeout", int'(ready_w[w]), 1);
            valid_w[w] = 1'b0;
            return;
        end
        acc_cyc = cyc + 1;
        if (w == 0) exp_q0.push_back(b);
        else exp_q1.push_back(b);
        @(negedge clk_10);
    endtask

    task automatic idle_inputs(input int w);
        valid_w[w] = 1'b0;
        data_w[w]  = 8'($urandom);
    endtask

    task automatic wait_start(input int w, input int n);
        int t = 0;
        while (nstart[w] < n && t < 3000) begin
            @(negedge clk_10);
            t++;
        end
        check_val("start_seen", int'(nstart[w] >= n), 1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk_10);
    endtask

    task automatic wait_idle(input int w);
        int t = 0;
        do begin
            @(negedge clk_10);
            t++;
        end while ((busy_w[w] || q_size(w) != 0) && t < 30000);
        check_val(w == 0 ? "drain_a" : "drain_b", int'(!busy_w[w] && q_size(w) == 0), 1);
    endtask

    initial begin
        int acc;
        bit st;
        int first_stall;
        int f0;
        int n0;
        int viol;
        int gap;

        data_w[0] = 8'h00;
        data_w[1] = 8'h00;
        repeat (3) @(negedge clk_10);
        reset_w = 2'b00;
        for (int w = 0; w < 2; w++) begin
            check_val("rst_uart", uart_w[w], 1);
            check_val("rst_busy", busy_w[w], 0);
            check_val("rst_ready", ready_w[w], 1);
        end

        viol = 0;
        repeat (1000) begin
            @(negedge clk_10);
            if (uart_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || ready_w[0] !== 1'b1) viol++;
        end
        check_val("idle_hold", viol, 0);

        // single byte: start latency and busy release
        n0 = nstart[0];
        send_byte(0, 8'h55, acc, st);
        idle_inputs(0);
        wait_start(0, n0 + 1);
        check_val("start_latency", last_start[0] - acc, 2);
        wait_cyc(last_start[0] + FRAME_BITS * CPB_A - 1);
        check_val("busy_before_end", busy_w[0], 1);
        @(negedge clk_10);
        check_val("busy_fall", busy_w[0], 0);
        wait_idle(0);

        // back-to-back frames with no idle gap
        f0 = nframes[0];
        send_byte(0, 8'h55, acc, st);
        send_byte(0, 8'h3F, acc, st);
        idle_inputs(0);
        wait_idle(0);
        check_val("b2b_frames", nframes[0] - f0, 2);
        check_val("b2b_gap", last_start[0] - prev_start[0], FRAME_BITS * CPB_A);

        // valid held: FIFO fills behind the byte in the shifter
        f0 = nframes[0];
        first_stall = -1;
        for (int i = 0; i < 6; i++) begin
            send_byte(0, 8'(i + 1), acc, st);
            if (st && first_stall < 0) first_stall = i;
        end
        idle_inputs(0);
        wait_idle(0);
        check_val("fill_stall_index", first_stall, 5);
        check_val("fill_frames", nframes[0] - f0, 6);

        // reset in the middle of data bit 3 with two bytes still queued
        n0 = nstart[0];
        send_byte(0, 8'hA5, acc, st);
        send_byte(0, 8'h11, acc, st);
        send_byte(0, 8'h22, acc, st);
        idle_inputs(0);
        wait_start(0, n0 + 1);
        wait_cyc(last_start[0] + 4 * CPB_A + CPB_A / 2);
        gen[0]++;
        reset_w[0] = 1'b1;
        @(negedge clk_10);
        reset_w[0] = 1'b0;
        exp_q0.delete();
        check_val("midrst_uart", uart_w[0], 1);
        check_val("midrst_busy", busy_w[0], 0);
        check_val("midrst_ready", ready_w[0], 1);
        f0 = nframes[0];
        viol = 0;
        repeat (3 * FRAME_BITS * CPB_A) begin
            @(negedge clk_10);
            if (uart_w[0] !== 1'b1 || busy_w[0] !== 1'b0) viol++;
        end
        check_val("post_reset_quiet", viol, 0);
        check_val("post_reset_frames", nframes[0] - f0, 0);

        // random bytes and gaps at the full bit period
        for (int i = 0; i < 6; i++) begin
            gap = $urandom_range(0, 1000);
            repeat (gap) @(negedge clk_10);
            send_byte(0, 8'($urandom), acc, st);
            idle_inputs(0);
        end
        wait_idle(0);

        // two clocks per bit: 0xFF then 0x00
        f0 = nframes[1];
        send_byte(1, 8'hFF, acc, st);
        send_byte(1, 8'h00, acc, st);
        idle_inputs(1);
        wait_idle(1);
        check_val("fast_frames", nframes[1] - f0, 2);
        check_val("fast_gap", last_start[1] - prev_start[1], FRAME_BITS * CPB_B);

        // random traffic on the fast instance
        f0 = nframes[1];
        for (int i = 0; i < 150; i++) begin
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 40) : $urandom_range(0, 3);
            repeat (gap) @(negedge clk_10);
            send_byte(1, 8'($urandom), acc, st);
            idle_inputs(1);
        end
        wait_idle(1);
        check_val("fast_random_frames", nframes[1] - f0, 150);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
